// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: ALU opcodes, instruction field
// positions and register-file geometry.
package risc_pkg;

    localparam int unsigned REG_N   = 8;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CTRL_W  = 3;

    localparam int unsigned CTRL_MSB = 15;
    localparam int unsigned CTRL_LSB = 13;
    localparam int unsigned RD_MSB   = 12;
    localparam int unsigned RD_LSB   = 10;
    localparam int unsigned RS1_MSB  = 9;
    localparam int unsigned RS1_LSB  = 7;
    localparam int unsigned RS2_MSB  = 6;
    localparam int unsigned RS2_LSB  = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SRL  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_NAND = 3'b100,
        ALU_SLL  = 3'b110
    } alu_ctrl_e;

    // 101 and 111 have no ALU operation behind them.
    function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
        return (c != 3'b101) && (c != 3'b111);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-stage bus: instruction handshake in, ALU operand handshake out,
// writeback return. master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                ex_valid;
    logic                ex_ready;
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
    logic [CTRL_W-1:0]   ctrl;
    logic [REG_AW-1:0]   ex_rd;
    logic                wb_en;
    logic [REG_AW-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                illegal;

    modport master (
        output in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
        input  in_ready, ex_valid, rs1, rs2, ctrl, ex_rd, illegal
    );

    modport slave (
        input  in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
        output in_ready, ex_valid, rs1, rs2, ctrl, ex_rd, illegal
    );
endinterface

// File: rtl/reg_file.sv
// 8-entry register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero.
module reg_file
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);
    logic [DATA_W-1:0] regs_q [REG_N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: busy scoreboard, RAW/WAW stall, ALU operand
// register. Define OF_WB_BYPASS_EN to forward same-cycle writebacks to sources.
module operand_fetch
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    operand_fetch_if.slave  bus
);
    logic [CTRL_W-1:0] ctrl_c;
    logic [REG_AW-1:0] rd_c, rs1a_c, rs2a_c;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, op1_c, op2_c;
    logic              haz1_c, haz2_c, hazrd_c, hazard_c, ready_c, accept_c;
    logic              unused_rsvd;

    logic [REG_N-1:0]  busy_q, busy_d;
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              illegal_q, illegal_d;

    assign ctrl_c      = bus.in_instr[CTRL_MSB:CTRL_LSB];
    assign rd_c        = bus.in_instr[RD_MSB:RD_LSB];
    assign rs1a_c      = bus.in_instr[RS1_MSB:RS1_LSB];
    assign rs2a_c      = bus.in_instr[RS2_MSB:RS2_LSB];
    assign unused_rsvd = ^bus.in_instr[RS2_LSB-1:0];

    reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1a_c),
        .raddr2_i (rs2a_c),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2),
        .we_i     (bus.wb_en),
        .waddr_i  (bus.wb_addr),
        .wdata_i  (bus.wb_data)
    );

    function automatic logic pending(input logic [REG_N-1:0] busy, input logic [REG_AW-1:0] r);
        return busy[r] && (r != '0);
    endfunction

`ifdef OF_WB_BYPASS_EN
    logic wb_hit1_c, wb_hit2_c;
    assign wb_hit1_c = bus.wb_en && (bus.wb_addr == rs1a_c) && (rs1a_c != '0);
    assign wb_hit2_c = bus.wb_en && (bus.wb_addr == rs2a_c) && (rs2a_c != '0);
    assign haz1_c    = pending(busy_q, rs1a_c) && !wb_hit1_c;
    assign haz2_c    = pending(busy_q, rs2a_c) && !wb_hit2_c;
    assign op1_c     = wb_hit1_c ? bus.wb_data : rf_rd1;
    assign op2_c     = wb_hit2_c ? bus.wb_data : rf_rd2;
`else
    assign haz1_c    = pending(busy_q, rs1a_c);
    assign haz2_c    = pending(busy_q, rs2a_c);
    assign op1_c     = rf_rd1;
    assign op2_c     = rf_rd2;
`endif

    // WAW on rd is never bypassed.
    assign hazrd_c  = pending(busy_q, rd_c);
    assign hazard_c = bus.in_valid && (haz1_c || haz2_c || hazrd_c);
    assign ready_c  = rst_n && (!ex_valid_q || bus.ex_ready) && !hazard_c;
    assign accept_c = bus.in_valid && ready_c;

    always_comb begin
        busy_d     = busy_q;
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        ctrl_d     = ctrl_q;
        ex_rd_d    = ex_rd_q;
        illegal_d  = 1'b0;

        if (ex_valid_q && bus.ex_ready) ex_valid_d = 1'b0;
        if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;

        // A same-cycle issue to the written register re-marks it busy.
        if (accept_c) begin
            if (ctrl_legal(ctrl_c)) begin
                ex_valid_d = 1'b1;
                rs1_d      = op1_c;
                rs2_d      = op2_c;
                ctrl_d     = ctrl_c;
                ex_rd_d    = rd_c;
                if (rd_c != '0) busy_d[rd_c] = 1'b1;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            ctrl_q     <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            ctrl_q     <= ctrl_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.in_ready = ready_c;
    assign bus.ex_valid = ex_valid_q;
    assign bus.rs1      = rs1_q;
    assign bus.rs2      = rs2_q;
    assign bus.ctrl     = ctrl_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, an architectural reference model
// compared every cycle, plus hand-computed literal checks.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    operand_fetch_if #(.DATA_W(8)) bus ();
    operand_fetch #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state of the stage as seen by software.
    logic [7:0] m_regs [8];
    bit         m_busy [8];
    bit         m_exv, m_ill, started;
    logic [7:0] m_rs1, m_rs2;
    logic [2:0] m_ctrl, m_rd;

    function automatic bit src_blocked(input logic [2:0] r);
        if (r == 3'd0 || !m_busy[r]) return 1'b0;
`ifdef OF_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] src_value(input logic [2:0] r);
        if (r == 3'd0) return 8'h00;
`ifdef OF_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
`endif
        return m_regs[r];
    endfunction

    function automatic bit m_ready();
        logic [15:0] ins;
        bit haz;
        if (rst_n !== 1'b1) return 1'b0;
        ins = bus.in_instr;
        haz = bus.in_valid && (src_blocked(ins[9:7]) || src_blocked(ins[6:4]) ||
              (ins[12:10] != 3'd0 && m_busy[ins[12:10]]));
        return (!m_exv || bus.ex_ready) && !haz;
    endfunction

    always @(posedge clk) begin : model
        logic [15:0] ins;
        logic [7:0]  va, vb;
        bit          acc;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 8'h00;
                m_busy[i] = 1'b0;
            end
            m_exv = 0; m_ill = 0; m_rs1 = 0; m_rs2 = 0; m_ctrl = 0; m_rd = 0;
            started = 1'b1;
        end else begin
            ins = bus.in_instr;
            acc = bus.in_valid && m_ready();
            va  = src_value(ins[9:7]);
            vb  = src_value(ins[6:4]);
            m_ill = 1'b0;
            if (m_exv && bus.ex_ready) m_exv = 1'b0;
            if (bus.wb_en) begin
                if (bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
                m_busy[bus.wb_addr] = 1'b0;
            end
            if (acc) begin
                if (ins[15:13] == 3'b101 || ins[15:13] == 3'b111) begin
                    m_ill = 1'b1;
                end else begin
                    m_exv  = 1'b1;
                    m_rs1  = va;
                    m_rs2  = vb;
                    m_ctrl = ins[15:13];
                    m_rd   = ins[12:10];
                    if (ins[12:10] != 3'd0) m_busy[ins[12:10]] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
            chk("ex_valid", 32'(bus.ex_valid), 32'(m_exv));
            chk("illegal",  32'(bus.illegal),  32'(m_ill));
            chk("rs1",      32'(bus.rs1),      32'(m_rs1));
            chk("rs2",      32'(bus.rs2),      32'(m_rs2));
            chk("ctrl",     32'(bus.ctrl),     32'(m_ctrl));
            chk("ex_rd",    32'(bus.ex_rd),    32'(m_rd));
        end
    end

    function automatic logic [15:0] mk(input logic [2:0] c, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {c, d, a, b, 4'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb(input logic [2:0] a, input logic [7:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        tick();
        bus.wb_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        started      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.ex_ready = 1'b1;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        tick();
        tick();
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_rs1",      32'(bus.rs1),      32'd0);
        chk("reset_illegal",  32'(bus.illegal),  32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;

        // Basic issue.
        wb(3'd1, 8'h05);
        wb(3'd2, 8'h01);
        bus.in_instr = mk(3'b000, 3'd3, 3'd1, 3'd2);
        bus.in_valid = 1'b1;
        tick();
        chk("add_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("add_rs1",      32'(bus.rs1),      32'h05);
        chk("add_rs2",      32'(bus.rs2),      32'h01);
        chk("add_ctrl",     32'(bus.ctrl),     32'd0);
        chk("add_ex_rd",    32'(bus.ex_rd),    32'd3);

        // RAW stall on r3 until its writeback.
        bus.in_instr = mk(3'b001, 3'd4, 3'd3, 3'd0);
        settle();
        chk("raw_stall0", 32'(bus.in_ready), 32'd0);
        tick();
        chk("raw_stall1", 32'(bus.in_ready), 32'd0);
        tick();
        chk("raw_stall2", 32'(bus.in_ready), 32'd0);
        bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 8'h06;
        settle();
`ifdef OF_WB_BYPASS_EN
        chk("byp_ready_on_wb", 32'(bus.in_ready), 32'd1);
        tick();
        bus.wb_en = 1'b0;
`else
        chk("nb_ready_on_wb", 32'(bus.in_ready), 32'd0);
        tick();
        bus.wb_en = 1'b0;
        settle();
        chk("nb_ready_after_wb", 32'(bus.in_ready), 32'd1);
        tick();
`endif
        bus.in_valid = 1'b0;
        chk("sub_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("sub_rs1",      32'(bus.rs1),      32'h06);
        chk("sub_ex_rd",    32'(bus.ex_rd),    32'd4);

        // Backpressure: held outputs stay stable.
        bus.ex_ready = 1'b0;
        bus.in_instr = mk(3'b000, 3'd5, 3'd1, 3'd2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_rs1",      32'(bus.rs1),      32'h06);
            chk("hold_ctrl",     32'(bus.ctrl),     32'd1);
        end
        bus.ex_ready = 1'b1;
        settle();
        chk("release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("release_rs1",   32'(bus.rs1),   32'h05);
        chk("release_ex_rd", 32'(bus.ex_rd), 32'd5);

        // Illegal opcode: dropped, pulse, no busy mark on r6.
        bus.in_instr = mk(3'b101, 3'd6, 3'd1, 3'd2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ill_pulse",    32'(bus.illegal),  32'd1);
        chk("ill_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("ill_rs1_hold", 32'(bus.rs1),      32'h05);
        tick();
        chk("ill_one_cycle", 32'(bus.illegal), 32'd0);

        // r0 reads zero and is never busy.
        wb(3'd0, 8'hFF);
        bus.in_instr = mk(3'b000, 3'd0, 3'd0, 3'd6);
        bus.in_valid = 1'b1;
        settle();
        chk("r6_not_busy", 32'(bus.in_ready), 32'd1);
        tick();
        chk("r0_rs1", 32'(bus.rs1),   32'h00);
        chk("r0_rd",  32'(bus.ex_rd), 32'd0);
        bus.in_instr = mk(3'b011, 3'd7, 3'd0, 3'd1);
        settle();
        chk("r0_no_stall", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("nor_rs2",  32'(bus.rs2),  32'h05);
        chk("nor_ctrl", 32'(bus.ctrl), 32'd3);

        // Reset mid-operation with r4 busy and an instruction held.
        bus.ex_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        bus.in_instr = mk(3'b000, 3'd1, 3'd4, 3'd5);
        bus.in_valid = 1'b1;
        settle();
        chk("rst_r4_free", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        chk("rst_issue_valid", 32'(bus.ex_valid), 32'd1);
        chk("rst_issue_rs1",   32'(bus.rs1),      32'h00);

        // Back-to-back independent issue.
        wb(3'd6, 8'h33);
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'b110, 3'd2, 3'd6, 3'd0);
        settle();
        chk("burst0_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_instr = mk(3'b010, 3'd3, 3'd6, 3'd0);
        settle();
        chk("burst1_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_instr = mk(3'b100, 3'd5, 3'd6, 3'd6);
        settle();
        chk("burst2_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("burst_rs2",  32'(bus.rs2),  32'h33);
        chk("burst_ctrl", 32'(bus.ctrl), 32'd4);
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch and issue stage of the 8-bit RISC core, directly upstream of the ALU. It accepts one 16-bit instruction per cycle over a valid/ready handshake and holds an 8×8 register file with a per-register busy scoreboard. It registers the ALU inputs (`rs1`, `rs2`, `ctrl`) together with the destination tag, and absorbs writeback results returning from the ALU side. Read-after-write (RAW) and write-after-write (WAW) hazards stall the stage instead of corrupting operands.

## Interface
- `DATA_W`, default 8: register and operand width.
- `clk`, in, 1: the only clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: `in_instr` is valid.
- `in_ready`, out, 1: the stage accepts `in_instr` this cycle.
- `in_instr`, in, 16: instruction word. Fields: [15:13] ctrl, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] reserved (ignored).
- `ex_valid`, out, 1: the ALU operand register holds an instruction.
- `ex_ready`, in, 1: the ALU side consumes the held instruction.
- `rs1`, out, DATA_W: ALU operand A.
- `rs2`, out, DATA_W: ALU operand B.
- `ctrl`, out, 3: ALU opcode.
- `ex_rd`, out, 3: destination tag travelling with the instruction.
- `wb_en`, in, 1: writeback strobe.
- `wb_addr`, in, 3: writeback register.
- `wb_data`, in, DATA_W: writeback value.
- `illegal`, out, 1: one-cycle pulse when an instruction with an undefined ctrl is accepted.

## Operation
- Legal ctrl values: 000 ADD, 001 SUB, 010 SRL, 011 NOR, 100 NAND, 110 SLL. Values 101 and 111 are illegal.
- r0 always reads 0. Writes to r0 are discarded, and r0 is never marked busy.
- A register is pending when `busy[r]` is set and r≠0.
- `hazard` = `in_valid` and (rs1 pending, or rs2 pending, or rd pending). The rd term blocks WAW. `hazard` is evaluated from `in_instr` combinationally.
- `in_ready` = (!`ex_valid` | `ex_ready`) & !`hazard`.
- Accept = `in_valid` & `in_ready`.
- Legal accept:
  - register file values are loaded into `rs1`/`rs2`;
  - `ctrl` and `ex_rd` are loaded;
  - `ex_valid` is set to 1;
  - `busy[rd]` is set (when rd≠0).
- Illegal accept:
  - the instruction is dropped and `illegal` pulses for one cycle;
  - `busy` is unchanged;
  - `ex_valid` clears if `ex_ready` is high that cycle, otherwise holds.
- `ex_valid` & `ex_ready` with no new legal accept: `ex_valid` goes to 0. The data outputs hold their last values.
- Writeback (`wb_en`): `regs[wb_addr]` ← `wb_data` and `busy[wb_addr]` is cleared.
  - If the same cycle's accept sets `busy` for the same register, the set wins.
  - A writeback to a non-busy register still updates the register file.
- The operand registers are stable while `ex_valid` & !`ex_ready`.

## Timing
- Reset values: `ex_valid`=0, `rs1`=0, `rs2`=0, `ctrl`=000, `ex_rd`=0, `illegal`=0, all `regs`=0, all `busy`=0.
- `in_ready` is 0 during the reset cycle.
- Reset asserted mid-operation discards the held instruction and clears all busy bits on that edge.
- Accept-to-`ex_valid` latency: 1 cycle.
- Throughput: 1 instruction per cycle when there are no hazards and `ex_ready` is held high.
- Dependent instruction: it stalls until the writeback of its source. Issue timing depends on the bypass macro (see Configuration).

## Configuration
- `OF_WB_BYPASS_EN` defined:
  - a writeback matching rs1 or rs2 in the same cycle clears that operand's hazard term;
  - `wb_data` is forwarded into the operand register;
  - the dependent instruction issues on the writeback edge.
- `OF_WB_BYPASS_EN` undefined:
  - the busy bit is the only release mechanism;
  - the dependent instruction issues one cycle after the writeback and reads the updated register file.
- The rd (WAW) term is never bypassed in either configuration.

## Structure
- `risc_pkg` holds:
  - `alu_ctrl_e` with the values above, plus a `ctrl_legal()` function;
  - instruction field position constants;
  - `REG_N`=8 and `REG_AW`=3.
- Sub-module `reg_file`:
  - 8×DATA_W storage;
  - two asynchronous read ports and one synchronous write port;
  - r0 hardwired to zero.
- Scoreboard, handshake logic and the operand register live in `operand_fetch`.

## Test plan
- Reset, then `wb_en` r1=5 and r2=1. Issue ADD rd=3, rs1=1, rs2=2 → next cycle `ex_valid`=1, `rs1`=0x05, `rs2`=0x01, `ctrl`=000, `ex_rd`=3.
- Issue ADD rd=3, then SUB rs1=3 with no writeback → `in_ready`=0 until `wb_en` r3=6.
  - Bypass build: SUB issues on the writeback edge with `rs1`=0x06.
  - Non-bypass build: SUB issues one cycle later with `rs1`=0x06.
- Hold `ex_ready`=0 with `ex_valid`=1 for 3 cycles → outputs are stable, `in_ready`=0. Release → the next instruction loads on the same edge.
- Instruction with ctrl=101 → accepted, `illegal`=1 for one cycle, `ex_valid` not set, `busy` unchanged.
- Read r0 after `wb_en` r0=0xFF → `rs1`=0x00. An issue with rd=0 never stalls a later reader of r0.
- Assert `rst_n`=0 while `ex_valid`=1 and r4 is busy → next cycle `ex_valid`=0 and r4 is readable without stall.
